// File: rtl/mul_pkg.sv
// Shared arithmetic-unit package: multiplier FSM encoding, default widths,
// and the divider-side constants used elsewhere in the codebase.
package mul_pkg;

   localparam int MUL_A_W = 16;
   localparam int MUL_B_W = 8;

   localparam int DIV_N_W = 16;
   localparam int DIV_D_W = 8;
   localparam int DIV_Q_W = DIV_N_W;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CALC = 3'd1,
      DONE = 3'd2
   } mul_state_t;

   // Bit-counter width; never zero so a 1-bit multiplier still gets a counter
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add step of the MSB-first multiplier: acc_next = 2*acc + (bit ? factor : 0).
module mul_step #(
   parameter int A_W = 16,
   parameter int P_W = 24
) (
   input  logic [P_W-1:0] acc,
   input  logic [A_W-1:0] factor,
   input  logic           bit_sel,
   output logic [P_W-1:0] acc_next
);

   logic [P_W-1:0] addend_s;

   // Select the partial product and fold it into the shifted accumulator
   always_comb begin
      addend_s = {P_W{1'b0}};
      if (bit_sel) begin
         addend_s = P_W'(factor);
      end else begin
         addend_s = {P_W{1'b0}};
      end
      acc_next = (acc << 1) + addend_s;
   end

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier: fixed B_W+1 cycle latency from accept
// to a one-cycle done pulse with a held, registered product.
module mul_seq
   import mul_pkg::*;
#(
   parameter int A_W = MUL_A_W,
   parameter int B_W = MUL_B_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [A_W-1:0]   factor,
   input  logic [B_W-1:0]   scale,
   input  logic             start,
   output logic [A_W+B_W-1:0] product,
   output logic             done,
   output logic             busy
);

   localparam int P_W   = A_W + B_W;
   localparam int CNT_W = cnt_width(B_W);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(B_W - 1);

   mul_state_t       state_r, state_nx_s;
   logic [CNT_W-1:0] cnt_r, cnt_nx_s;
   logic [P_W-1:0]   acc_r, acc_nx_s, step_s;
   logic [A_W-1:0]   factor_r, factor_nx_s;
   logic [B_W-1:0]   scale_r, scale_nx_s;
   logic [P_W-1:0]   product_r, product_nx_s;
   logic             done_r, done_nx_s;

   mul_step #(
      .A_W (A_W),
      .P_W (P_W)
   ) u_step (
      .acc      (acc_r),
      .factor   (factor_r),
      .bit_sel  (scale_r[cnt_r]),
      .acc_next (step_s)
   );

   // State register plus datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r   <= IDLE;
         cnt_r     <= CNT_LOAD;
         acc_r     <= {P_W{1'b0}};
         factor_r  <= {A_W{1'b0}};
         scale_r   <= {B_W{1'b0}};
         product_r <= {P_W{1'b0}};
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         cnt_r     <= cnt_nx_s;
         acc_r     <= acc_nx_s;
         factor_r  <= factor_nx_s;
         scale_r   <= scale_nx_s;
         product_r <= product_nx_s;
         done_r    <= done_nx_s;
      end
   end

   // Next-state and next-datapath logic; everything holds unless the state says otherwise
   always_comb begin
      state_nx_s   = state_r;
      cnt_nx_s     = cnt_r;
      acc_nx_s     = acc_r;
      factor_nx_s  = factor_r;
      scale_nx_s   = scale_r;
      product_nx_s = product_r;
      done_nx_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               factor_nx_s = factor;
               scale_nx_s  = scale;
               acc_nx_s    = {P_W{1'b0}};
               cnt_nx_s    = CNT_LOAD;
               state_nx_s  = CALC;
            end else begin
               state_nx_s  = IDLE;
            end
         end
         CALC: begin
            acc_nx_s = step_s;
            if (cnt_r == {CNT_W{1'b0}}) begin
               state_nx_s = DONE;
            end else begin
               cnt_nx_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         DONE: begin
            product_nx_s = acc_r;
            done_nx_s    = 1'b1;
            state_nx_s   = IDLE;
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   assign product = product_r;
   assign done    = done_r;
   assign busy    = (state_r != IDLE);

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq with hand-computed products.
module tb_mul_seq;

   logic        clk;
   logic        reset;
   logic [15:0] factor;
   logic [7:0]  scale;
   logic        start;
   logic [23:0] product;
   logic        done;
   logic        busy;

   int checks;
   int failures;

   mul_seq #(.A_W(16), .B_W(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .factor  (factor),
      .scale   (scale),
      .start   (start),
      .product (product),
      .done    (done),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse start for one accept edge, then wait (bounded) for done.
   // lat counts edges after accept; busy_cnt counts busy-high samples from the accept edge.
   task automatic do_mul(input logic [15:0] a, input logic [7:0] b,
                         output logic [23:0] p, output int lat, output int busy_cnt);
      @(posedge clk); #1;
      factor = a; scale = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      busy_cnt = busy ? 1 : 0;
      while (!done && lat < 30) begin
         @(posedge clk); #1;
         lat++;
         if (busy) busy_cnt++;
      end
      if (!done) lat = -1;
      p = product;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; factor = 16'h0000; scale = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (product !== 24'h000000 || done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: product=%h done=%b busy=%b, required 000000/0/0", product, done, busy);
      end
      reset = 1'b1;
   endtask

   task automatic test_basic();
      logic [23:0] p; int lat; int bc;
      do_mul(16'h1234, 8'h56, p, lat, bc);
      checks++;
      if (p !== 24'h061D78) begin
         failures++; $display("FAIL basic_product: got %h, required 061d78", p);
      end
      checks++;
      if (lat !== 9) begin
         failures++; $display("FAIL basic_latency: got %0d, required 9", lat);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         failures++; $display("FAIL done_one_cycle: done=%b, required 0", done);
      end
      // operands wiggle in IDLE; product must hold
      factor = 16'hFFFF; scale = 8'hFF;
      repeat (3) @(posedge clk); #1;
      checks++;
      if (product !== 24'h061D78 || busy !== 1'b0) begin
         failures++; $display("FAIL idle_hold: product=%h busy=%b, required 061d78/0", product, busy);
      end
   endtask

   task automatic test_max();
      logic [23:0] p; int lat; int bc;
      do_mul(16'hFFFF, 8'hFF, p, lat, bc);
      checks++;
      if (p !== 24'hFEFF01) begin
         failures++; $display("FAIL max_product: got %h, required feff01", p);
      end
      checks++;
      if (bc !== 9) begin
         failures++; $display("FAIL max_busy_cycles: got %0d, required 9", bc);
      end
   endtask

   task automatic test_zero();
      logic [23:0] p; int lat; int bc;
      do_mul(16'hABCD, 8'h00, p, lat, bc);
      checks++;
      if (p !== 24'h000000 || lat !== 9) begin
         failures++; $display("FAIL zero_scale: product=%h lat=%0d, required 000000/9", p, lat);
      end
      do_mul(16'h0000, 8'h55, p, lat, bc);
      checks++;
      if (p !== 24'h000000 || lat !== 9) begin
         failures++; $display("FAIL zero_factor: product=%h lat=%0d, required 000000/9", p, lat);
      end
   endtask

   task automatic test_ignore_start();
      int c;
      @(posedge clk); #1;
      factor = 16'h0003; scale = 8'h05; start = 1'b1;
      @(posedge clk); #1;
      c = 0;
      // hold start with new operands through CALC, drop it before done
      factor = 16'h7777; scale = 8'h99;
      while (!done && c < 30) begin
         if (c == 7) start = 1'b0;
         @(posedge clk); #1;
         c++;
      end
      start = 1'b0;
      checks++;
      if (product !== 24'h00000F || c !== 9) begin
         failures++; $display("FAIL ignore_start: product=%h lat=%0d, required 00000f/9", product, c);
      end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL no_queue: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      int c; int n_done;
      int         done_at [3];
      logic [23:0] res    [3];
      int         exp_at  [3];
      logic [23:0] exp_res [3];
      exp_at = '{9, 19, 29};
      exp_res = '{24'h000022, 24'h001000, 24'h00807F};
      @(posedge clk); #1;
      factor = 16'h0011; scale = 8'h02; start = 1'b1;
      @(posedge clk); #1;
      c = 0; n_done = 0;
      while (c < 40) begin
         if (c == 3)  begin factor = 16'h0100; scale = 8'h10; end
         if (c == 13) begin factor = 16'h00FF; scale = 8'h81; end
         if (c == 29) start = 1'b0;
         @(posedge clk); #1;
         c++;
         if (done) begin
            if (n_done < 3) begin
               done_at[n_done] = c;
               res[n_done] = product;
            end
            n_done++;
         end
      end
      checks++;
      if (n_done !== 3) begin
         failures++; $display("FAIL b2b_count: got %0d results, required 3", n_done);
      end
      for (int i = 0; i < 3; i++) begin
         if (i < n_done) begin
            checks++;
            if (done_at[i] !== exp_at[i] || res[i] !== exp_res[i]) begin
               failures++;
               $display("FAIL b2b_result%0d: cycle=%0d product=%h, required %0d/%h",
                        i, done_at[i], res[i], exp_at[i], exp_res[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [23:0] p; int lat; int bc; int seen;
      @(posedge clk); #1;
      factor = 16'h0102; scale = 8'h03; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      checks++;
      if (busy !== 1'b0 || product !== 24'h000000 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_calc: busy=%b product=%h done=%b, required 0/000000/0", busy, product, done);
      end
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++; $display("FAIL reset_no_done: saw %0d done pulses, required 0", seen);
      end
      do_mul(16'h0102, 8'h03, p, lat, bc);
      checks++;
      if (p !== 24'h000306 || lat !== 9) begin
         failures++; $display("FAIL after_reset: product=%h lat=%0d, required 000306/9", p, lat);
      end
      // reset wins over a simultaneous start
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1; start = 1'b0;
      checks++;
      if (busy !== 1'b0 || product !== 24'h000000) begin
         failures++; $display("FAIL reset_priority: busy=%b product=%h, required 0/000000", busy, product);
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      reset = 1'b0; start = 1'b0; factor = 16'h0000; scale = 8'h00;
      test_reset();
      test_basic();
      test_max();
      test_zero();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
